// File: rtl/psum_collector.sv
// psum_collector: de-skews systolic-array column psums, queues aligned
// rows in a FIFO and tracks job completion with a small FSM.
module psum_collector #(
  parameter int COLS   = 4,
  parameter int PSUM_W = 32,
  parameter int SKEW   = 3,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_rows,
  input  logic                   in_valid,
  input  logic [COLS*PSUM_W-1:0] in_psum,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COLS*PSUM_W-1:0] out_data,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int DW  = COLS * PSUM_W;
  localparam int LAT = (COLS - 1) * SKEW;
  localparam int AW  = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0]    algn_data;
  logic             algn_valid;
  logic [CNT_W-1:0] num_rows_q;
  logic [CNT_W-1:0] pushed_cnt;

  logic [DW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             push_req;
  logic             push_ok;
  logic             pop;

  for (genvar j = 0; j < COLS; j++) begin : g_col
    localparam int D = (COLS - 1 - j) * SKEW;
    if (D == 0) begin : g_pass
      assign algn_data[j*PSUM_W +: PSUM_W] =
        in_psum[j*PSUM_W +: PSUM_W];
    end else begin : g_dly
      logic [PSUM_W-1:0] sr [D];
      // shift column j down its alignment delay line
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < D; i++) sr[i] <= '0;
        end else begin
          sr[0] <= in_psum[j*PSUM_W +: PSUM_W];
          for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
      end
      assign algn_data[j*PSUM_W +: PSUM_W] = sr[D-1];
    end
  end

  if (LAT == 0) begin : g_vpass
    assign algn_valid = in_valid;
  end else begin : g_vdly
    logic vsr [LAT];
    // delay column-0 valid to line up with the last column
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < LAT; i++) vsr[i] <= 1'b0;
      end else begin
        vsr[0] <= in_valid;
        for (int i = 1; i < LAT; i++) vsr[i] <= vsr[i-1];
      end
    end
    assign algn_valid = vsr[LAT-1];
  end

  assign full     = count[AW];
  assign empty    = (count == '0);
  assign push_req = algn_valid && (state == COLLECT) &&
                    (pushed_cnt < num_rows_q);
  assign pop      = out_valid && out_ready;
  assign push_ok  = push_req && (!full || pop);

  assign out_valid = !empty;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // row storage; a full FIFO only takes a row when a pop frees a slot
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= algn_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
    end
  end

  // job bookkeeping: row target, attempted pushes, sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      num_rows_q <= '0;
      pushed_cnt <= '0;
      overflow   <= 1'b0;
    end else if (state == IDLE && start) begin
      num_rows_q <= num_rows;
      pushed_cnt <= '0;
      overflow   <= 1'b0;
    end else if (push_req) begin
      pushed_cnt <= pushed_cnt + 1'b1;
      if (full && !pop) overflow <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next state and status outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = (num_rows == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        busy = 1'b1;
        if (pushed_cnt == num_rows_q) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (empty) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: directed job sequence with randomized data/ready,
// checked against a row-level model of the expected output stream.
module tb_psum_collector;

  localparam int COLS   = 4;
  localparam int PSUM_W = 32;
  localparam int SKEW   = 3;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;
  localparam int DW     = COLS * PSUM_W;
  localparam int LAT    = (COLS - 1) * SKEW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_rows = '0;
  logic             in_valid = 1'b0;
  logic [DW-1:0]    in_psum = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    out_data;
  logic             busy;
  logic             done;
  logic             overflow;

  int n_tests = 0;
  int n_fail  = 0;

  int            rt[$];
  logic [DW-1:0] rd[$];
  bit            garb_fixed = 1'b0;
  int            restart_c = 0;
  int            abort_c = 0;

  psum_collector #(
    .COLS(COLS), .PSUM_W(PSUM_W), .SKEW(SKEW),
    .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .in_valid(in_valid), .in_psum(in_psum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_row();
    logic [DW-1:0] r;
    for (int j = 0; j < COLS; j++) r[j*PSUM_W +: PSUM_W] = $urandom;
    return r;
  endfunction

  // column j of a row scheduled at t is presented at t + j*SKEW
  task automatic set_inputs(input int c);
    logic [DW-1:0] p;
    bit v;
    v = 1'b0;
    for (int j = 0; j < COLS; j++)
      p[j*PSUM_W +: PSUM_W] = garb_fixed ? 32'hDEAD : $urandom;
    for (int k = 0; k < rt.size(); k++) begin
      if (rt[k] == c) v = 1'b1;
      for (int j = 0; j < COLS; j++)
        if (rt[k] + j*SKEW == c)
          p[j*PSUM_W +: PSUM_W] = rd[k][j*PSUM_W +: PSUM_W];
    end
    in_valid = v;
    in_psum  = p;
  endtask

  // mode 0: ready high, 1: ready low until rel_c, 2: random ready
  task automatic run_job(input int n, input int mode, input int rel_c);
    logic [DW-1:0] exp_q[$];
    int            exp_t[$];
    int            n_exp, t, done_n, done_c, first_v, c;
    bit            busy_seen, pv, pr, fin, aborted;
    logic [DW-1:0] pd;
    n_exp = (mode == 1 && n > DEPTH) ? DEPTH : n;
    for (int k = 0; k < n_exp; k++) begin
      exp_q.push_back(rd[k]);
      exp_t.push_back(rt[k] + LAT + 1);
    end
    done_n = 0; done_c = -1; first_v = -1;
    busy_seen = 0; pv = 0; pr = 0; pd = '0;
    fin = 0; aborted = 0;
    for (c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c >= rel_c);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
      if (abort_c > 0 && c == abort_c + 1) begin
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_overflow", overflow, 0);
        chk("abort_done", done, 0);
        chk("abort_out_data", out_data, 0);
        rst = 1'b0;
        abort_c = 0;
        aborted = 1;
        fin = 1;
      end else begin
        if (busy) busy_seen = 1;
        if (pv && !pr) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, pd);
        end
        if (out_valid && first_v < 0) begin
          first_v = c;
          if (rt.size() > 0) chk("first_latency", c, rt[0] + LAT + 1);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_row", out_valid, 0);
          end else begin
            chk("row_data", out_data, exp_q.pop_front());
            t = exp_t.pop_front();
            if (mode == 0) chk("row_time", c, t);
          end
        end
        if (mode == 1 && n > DEPTH) begin
          if (c == rt[DEPTH] + LAT) chk("ovf_before", overflow, 0);
          if (c == rt[DEPTH] + LAT + 1) chk("ovf_set", overflow, 1);
        end
        if (done) begin
          done_n++;
          chk("done_drained", exp_q.size(), 0);
          if (done_c < 0) done_c = c;
        end
        if (done_c >= 0 && c >= done_c + 3) fin = 1;
        pv = out_valid; pr = out_ready; pd = out_data;
        start = (c == 0) || (restart_c > 0 && c == restart_c);
        num_rows = (c == 0) ? CNT_W'(n) : CNT_W'(1);
        if (abort_c > 0 && c == abort_c) begin
          chk("pre_abort_busy", busy, 1);
          chk("pre_abort_valid", out_valid, 1);
          rst = 1'b1;
        end
        set_inputs(c);
      end
    end
    chk("job_finished", fin, 1);
    if (!aborted) begin
      chk("done_count", done_n, 1);
      chk("rows_left", exp_q.size(), 0);
      chk("overflow_end", overflow, (mode == 1 && n > DEPTH));
      chk("busy_seen", busy_seen, (n != 0));
      chk("end_out_valid", out_valid, 0);
      chk("end_busy", busy, 0);
    end
    start = 1'b0; in_valid = 1'b0; in_psum = '0; out_ready = 1'b0;
    restart_c = 0; garb_fixed = 1'b0;
    rt.delete(); rd.delete();
  endtask

  task automatic first_scenario();
    logic [DW-1:0] r;
    garb_fixed = 1'b1;
    r = {32'h44, 32'h33, 32'h22, 32'h11};
    rt.push_back(10); rd.push_back(r);
    run_job(1, 0, 0);
  endtask

  task automatic idle_noise();
    bit sv, sb;
    sv = 0; sb = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) sv = 1;
      if (busy) sb = 1;
      in_valid = (c < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_psum = rnd_row();
    end
    chk("idle_no_output", sv, 0);
    chk("idle_no_busy", sb, 0);
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    int t;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;

    first_scenario();

    for (int k = 0; k < 16; k++) begin
      rt.push_back(1 + k);
      rd.push_back({COLS{32'(k + 1)}});
    end
    run_job(16, 0, 0);

    for (int k = 0; k < 10; k++) begin
      rt.push_back(1 + k);
      rd.push_back(rnd_row());
    end
    run_job(10, 1, 10 + LAT + 5);

    t = 1;
    for (int k = 0; k < 8; k++) begin
      rt.push_back(t);
      rd.push_back(rnd_row());
      t += $urandom_range(1, 4);
    end
    run_job(6, 2, 0);

    run_job(0, 0, 0);

    for (int k = 0; k < 4; k++) begin
      rt.push_back(2 + 2*k);
      rd.push_back(rnd_row());
    end
    restart_c = 5;
    run_job(4, 0, 0);

    idle_noise();

    for (int k = 0; k < 3; k++) begin
      rt.push_back(2 + k);
      rd.push_back(rnd_row());
    end
    abort_c = 4 + LAT + 4;
    run_job(3, 1, 1000);

    first_scenario();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
